// File: rtl/snake_step_ctrl_if.sv
// Handshake bundle between the snake step controller and the game logic around it.
// master drives the sync, buttons and game controls; slave is the controller.
interface snake_step_ctrl_if;
    logic       v_sync;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       start;
    logic       pause;
    logic       collide;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [1:0] direction;
    logic       step;
    logic [1:0] state;
    logic       dead;

    modport master (
        output v_sync, btn_up, btn_down, btn_left, btn_right, start, pause, collide,
        input  head_x, head_y, direction, step, state, dead
    );

    modport slave (
        input  v_sync, btn_up, btn_down, btn_left, btn_right, start, pause, collide,
        output head_x, head_y, direction, step, state, dead
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: frame-rate head stepping, direction arbitration, run/pause/dead state.
// Define SNAKE_WRAP_EN to make the head wrap at the screen edges instead of dying.
module snake_step_ctrl #(
    parameter int FRAMES_PER_STEP = 10,
    parameter int GRID            = 10,
    parameter int X_MAX           = 640,
    parameter int Y_MAX           = 480,
    parameter int START_X         = 320,
    parameter int START_Y         = 240
) (
    input logic              clk,
    input logic              reset,
    snake_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_LEFT  = 2'd1;
    localparam logic [1:0]  DIR_RIGHT = 2'd2;
    localparam logic [1:0]  DIR_DOWN  = 2'd3;
    localparam logic [10:0] L_GRID11  = 11'(GRID);
    localparam logic [10:0] L_XLIM11  = 11'(X_MAX - GRID);
    localparam logic [10:0] L_YLIM11  = 11'(Y_MAX - GRID);
    localparam logic [9:0]  L_GRID10  = 10'(GRID);
    localparam logic [9:0]  L_START_X = 10'(START_X);
    localparam logic [9:0]  L_START_Y = 10'(START_Y);
    localparam logic [5:0]  L_LAST    = 6'(FRAMES_PER_STEP - 1);
`ifdef SNAKE_WRAP_EN
    localparam logic [9:0]  L_XLIM10  = 10'(X_MAX - GRID);
    localparam logic [9:0]  L_YLIM10  = 10'(Y_MAX - GRID);
`endif

    logic       r_syncMeta, r_sync, r_syncDly;
    logic       w_frameTick;
    state_t     r_state, w_nextState;
    logic [5:0] r_count, w_nextCount;
    logic [9:0] r_headX, r_headY, w_nextX, w_nextY, w_moveX, w_moveY;
    logic [1:0] r_dir, r_pendDir, w_nextDir, w_nextPend, w_cand;
    logic       r_step, w_nextStep;
    logic       w_oneBtn, w_hitWall;

    // v_sync is asynchronous: two flops to settle it, a third to find the rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_syncMeta <= 1'b0;
            r_sync     <= 1'b0;
            r_syncDly  <= 1'b0;
        end else begin
            r_syncMeta <= bus.v_sync;
            r_sync     <= r_syncMeta;
            r_syncDly  <= r_sync;
        end
    end

    assign w_frameTick = r_sync & ~r_syncDly;

    always_comb begin
        w_oneBtn = 1'b1;
        w_cand   = DIR_UP;
        case ({bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_up})
            4'b0001: w_cand = DIR_UP;
            4'b0010: w_cand = DIR_LEFT;
            4'b0100: w_cand = DIR_RIGHT;
            4'b1000: w_cand = DIR_DOWN;
            default: w_oneBtn = 1'b0;
        endcase
    end

    // Wall test in 11 bits so the right/bottom edge sum cannot overflow
    always_comb begin
        w_hitWall = 1'b0;
        w_moveX   = r_headX;
        w_moveY   = r_headY;
        case (r_pendDir)
            DIR_UP: begin
                w_hitWall = ({1'b0, r_headY} < L_GRID11);
                w_moveY   = r_headY - L_GRID10;
`ifdef SNAKE_WRAP_EN
                if (w_hitWall) w_moveY = L_YLIM10;
`endif
            end
            DIR_LEFT: begin
                w_hitWall = ({1'b0, r_headX} < L_GRID11);
                w_moveX   = r_headX - L_GRID10;
`ifdef SNAKE_WRAP_EN
                if (w_hitWall) w_moveX = L_XLIM10;
`endif
            end
            DIR_RIGHT: begin
                w_hitWall = (({1'b0, r_headX} + L_GRID11) > L_XLIM11);
                w_moveX   = r_headX + L_GRID10;
`ifdef SNAKE_WRAP_EN
                if (w_hitWall) w_moveX = '0;
`endif
            end
            default: begin
                w_hitWall = (({1'b0, r_headY} + L_GRID11) > L_YLIM11);
                w_moveY   = r_headY + L_GRID10;
`ifdef SNAKE_WRAP_EN
                if (w_hitWall) w_moveY = '0;
`endif
            end
        endcase
    end

    // Collide outranks pause, which outranks the stepping tick
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextX     = r_headX;
        w_nextY     = r_headY;
        w_nextDir   = r_dir;
        w_nextPend  = r_pendDir;
        w_nextStep  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nextCount = '0;
                if (bus.start) w_nextState = ST_RUN;
            end
            ST_RUN: begin
                if (bus.collide) begin
                    w_nextState = ST_DEAD;
                end else if (bus.pause) begin
                    w_nextState = ST_PAUSE;
                end else begin
                    if (w_oneBtn && (w_cand != ~r_dir)) w_nextPend = w_cand;
                    if (w_frameTick) begin
                        if (r_count == L_LAST) begin
                            w_nextCount = '0;
                            w_nextDir   = r_pendDir;
`ifdef SNAKE_WRAP_EN
                            w_nextX    = w_moveX;
                            w_nextY    = w_moveY;
                            w_nextStep = 1'b1;
`else
                            if (w_hitWall) begin
                                w_nextState = ST_DEAD;
                            end else begin
                                w_nextX    = w_moveX;
                                w_nextY    = w_moveY;
                                w_nextStep = 1'b1;
                            end
`endif
                        end else begin
                            w_nextCount = r_count + 6'd1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (!bus.pause) w_nextState = ST_RUN;
            end
            default: begin
                if (bus.start) begin
                    w_nextState = ST_IDLE;
                    w_nextCount = '0;
                    w_nextX     = L_START_X;
                    w_nextY     = L_START_Y;
                    w_nextDir   = DIR_RIGHT;
                    w_nextPend  = DIR_RIGHT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_headX   <= L_START_X;
            r_headY   <= L_START_Y;
            r_dir     <= DIR_RIGHT;
            r_pendDir <= DIR_RIGHT;
            r_step    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_nextCount;
            r_headX   <= w_nextX;
            r_headY   <= w_nextY;
            r_dir     <= w_nextDir;
            r_pendDir <= w_nextPend;
            r_step    <= w_nextStep;
        end
    end

    assign bus.head_x    = r_headX;
    assign bus.head_y    = r_headY;
    assign bus.direction = r_dir;
    assign bus.step      = r_step;
    assign bus.state     = r_state;
    assign bus.dead      = (r_state == ST_DEAD);
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Randomized bench for snake_step_ctrl: operations are applied one at a time and checked
// against a game-level model of head position, direction, step count and game state.
module tb_snake_step_ctrl;
    localparam int F     = 10;
    localparam int GRID  = 10;
    localparam int XMAX  = 640;
    localparam int YMAX  = 480;
    localparam int SX    = 320;
    localparam int SY    = 240;

    logic clk = 1'b0;
    logic reset;
    snake_step_ctrl_if bus();

    snake_step_ctrl #(
        .FRAMES_PER_STEP(F), .GRID(GRID), .X_MAX(XMAX), .Y_MAX(YMAX),
        .START_X(SX), .START_Y(SY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   stepCount = 0;
    int   wideCount = 0;
    logic prevStep = 1'b0;

    always @(posedge clk) begin
        if (bus.step === 1'b1) stepCount <= stepCount + 1;
        if (bus.step === 1'b1 && prevStep) wideCount <= wideCount + 1;
        prevStep <= (bus.step === 1'b1);
    end

    // Game-level model: state 0 idle, 1 run, 2 pause, 3 dead; direction as a unit vector
    int mState, mX, mY, mDir, mPend, mCount, mSteps;
    bit pauseLvl;

    function automatic int dxOf(int d);
        if (d == 1) return -1;
        if (d == 2) return 1;
        return 0;
    endfunction

    function automatic int dyOf(int d);
        if (d == 0) return -1;
        if (d == 3) return 1;
        return 0;
    endfunction

    task automatic modelReset();
        mState = 0; mX = SX; mY = SY; mDir = 2; mPend = 2; mCount = 0;
    endtask

    task automatic modelFrame();
        int nx, ny;
        bit outside;
        if (mState != 1) return;
        mCount++;
        if (mCount < F) return;
        mCount = 0;
        mDir = mPend;
        nx = mX + dxOf(mDir) * GRID;
        ny = mY + dyOf(mDir) * GRID;
        outside = (nx < 0) || (nx > XMAX - GRID) || (ny < 0) || (ny > YMAX - GRID);
`ifdef SNAKE_WRAP_EN
        if (nx < 0) nx = XMAX - GRID; else if (nx > XMAX - GRID) nx = 0;
        if (ny < 0) ny = YMAX - GRID; else if (ny > YMAX - GRID) ny = 0;
        outside = 1'b0;
`endif
        if (outside) begin
            mState = 3;
        end else begin
            mX = nx; mY = ny; mSteps++;
        end
    endtask

    task automatic modelPress(int mask);
        int cand;
        if (mState != 1 || $countones(4'(mask)) != 1) return;
        cand = 0;
        for (int i = 0; i < 4; i++) if (mask == (1 << i)) cand = i;
        if (!(dxOf(cand) == -dxOf(mDir) && dyOf(cand) == -dyOf(mDir))) mPend = cand;
    endtask

    task automatic checkOutput(string tag, int observed, int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("state", int'(bus.state), mState);
        checkOutput("head_x", int'(bus.head_x), mX);
        checkOutput("head_y", int'(bus.head_y), mY);
        checkOutput("direction", int'(bus.direction), mDir);
        checkOutput("dead", int'(bus.dead), (mState == 3) ? 1 : 0);
        checkOutput("stepCount", stepCount, mSteps);
        checkOutput("stepWidth", wideCount, 0);
    endtask

    // op: 0 frame, 1 press(arg=mask), 2 start, 3 pause(arg=level), 4 collide on tick, 5 reset
    task automatic applyStimulus(int op, int arg);
        case (op)
            0: begin
                bus.v_sync = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus.v_sync = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                modelFrame();
            end
            1: begin
                {bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_up} = 4'(arg);
                repeat (2) @(posedge clk);
                #1 {bus.btn_down, bus.btn_right, bus.btn_left, bus.btn_up} = 4'b0;
                @(posedge clk);
                #1;
                modelPress(arg);
            end
            2: begin
                bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
                @(posedge clk);
                #1;
                if (mState == 0) mState = pauseLvl ? 2 : 1;
                else if (mState == 3) modelReset();
            end
            3: begin
                bus.pause = arg[0];
                pauseLvl = arg[0];
                repeat (2) @(posedge clk);
                #1;
                if (mState == 1 && pauseLvl) mState = 2;
                else if (mState == 2 && !pauseLvl) mState = 1;
            end
            4: begin
                bus.v_sync = 1'b1;
                repeat (2) @(posedge clk);
                #1 bus.collide = 1'b1;
                @(posedge clk);
                #1 bus.collide = 1'b0;
                bus.v_sync = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                if (mState == 1) mState = 3;
            end
            default: begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                modelReset();
            end
        endcase
        checkAll();
    endtask

    initial begin
        int r;
        int mask;
        reset = 1'b1;
        {bus.v_sync, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = '0;
        {bus.start, bus.pause, bus.collide} = '0;
        pauseLvl = 1'b0;
        mSteps = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkAll();
        checkOutput("rstStep", int'(bus.step), 0);

        applyStimulus(2, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0);
        checkOutput("firstStepX", int'(bus.head_x), 330);
        checkOutput("firstStepCnt", stepCount, 1);

        applyStimulus(1, 4'b0010);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0);
        checkOutput("reverseIgnoredX", int'(bus.head_x), 340);

        applyStimulus(1, 4'b0001);
        applyStimulus(1, 4'b0011);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0);
        checkOutput("upY", int'(bus.head_y), 230);
        checkOutput("upDir", int'(bus.direction), 0);

        for (int i = 0; i < 5; i++) applyStimulus(0, 0);
        applyStimulus(3, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0);
        applyStimulus(3, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0);
        checkOutput("pauseResumeCnt", stepCount, 4);

        for (int i = 0; i < 9; i++) applyStimulus(0, 0);
        applyStimulus(4, 0);
        checkOutput("collideY", int'(bus.head_y), 220);

        applyStimulus(2, 0);
        applyStimulus(2, 0);
        for (int i = 0; i < 310; i++) applyStimulus(0, 0);
        checkOutput("edgeX", int'(bus.head_x), 630);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0);
`ifdef SNAKE_WRAP_EN
        checkOutput("wrapX", int'(bus.head_x), 0);
`else
        checkOutput("wallState", int'(bus.state), 3);
        checkOutput("wallX", int'(bus.head_x), 630);
`endif
        applyStimulus(2, 0);
        applyStimulus(2, 0);
        for (int i = 0; i < 23; i++) applyStimulus(0, 0);
        applyStimulus(5, 0);
        checkOutput("midResetX", int'(bus.head_x), 320);

        for (int n = 0; n < 700; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                applyStimulus(0, 0);
            end else if (r < 75) begin
                mask = ($urandom_range(0, 9) < 7) ? (1 << $urandom_range(0, 3)) : $urandom_range(0, 15);
                applyStimulus(1, mask);
            end else if (r < 83) begin
                applyStimulus(2, 0);
            end else if (r < 91) begin
                applyStimulus(3, $urandom_range(0, 1));
            end else if (r < 96) begin
                applyStimulus(4, 0);
            end else begin
                applyStimulus(5, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
